// File: rtl/wb_initiator.sv
// wb_initiator: pipelined Wishbone initiator that expands one command strobe
// into a burst of 1..2^LGLEN single-word requests on a stall/ack bus.
// Read words come back on o_rsp_stb/o_rsp_data. o_done/o_err report the end
// of a burst or an abort.
// Optional feature: define WB_INITIATOR_TIMEOUT_EN to build a TOW-bit
// inactivity counter. It aborts a burst when the slave goes silent.
module wb_initiator #(
    parameter int AW    = 30,
    parameter int DW    = 32,
    parameter int LGLEN = 4,
    parameter int TOW   = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_stb,
    input  logic             i_cmd_we,
    input  logic [AW-1:0]    i_cmd_addr,
    input  logic [DW-1:0]    i_cmd_data,
    input  logic [LGLEN-1:0] i_cmd_len,
    output logic             o_busy,
    output logic             o_rsp_stb,
    output logic [DW-1:0]    o_rsp_data,
    output logic             o_done,
    output logic             o_err,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [AW-1:0]    o_wb_addr,
    output logic [DW-1:0]    o_wb_data,
    input  logic             i_wb_stall,
    input  logic             i_wb_ack,
    input  logic             i_wb_err,
    input  logic [DW-1:0]    i_wb_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    localparam logic [LGLEN:0] CNT_ONE  = {{LGLEN{1'b0}}, 1'b1};
    localparam logic [AW-1:0]  ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    // The timeout compare needs at least a two-bit counter
    generate
        if (TOW < 2) begin : g_tow_check
            $error("wb_initiator: TOW must be at least 2");
        end
    endgenerate

    state_t         state;
    state_t         state_d;

    // Beat bookkeeping is one bit wider than i_cmd_len so a full 2^LGLEN burst
    // can be counted without wrapping.
    logic [LGLEN:0] n_beats;
    logic [LGLEN:0] issued;
    logic [LGLEN:0] acked;

    logic           cmd_accept;
    logic           beat_acc;
    logic           ack_v;
    logic           err_v;
    logic           timeout_v;
    logic           abort;
    logic           last_ack;
    logic           last_beat;

    logic           busy_d;
    logic           cyc_d;
    logic           stb_d;
    logic           rsp_stb_d;
    logic           done_d;
    logic           err_d;

    // Bus events for this cycle. An ack that arrives with an error is not
    // counted, and abort wins over everything else.
    always_comb begin
        cmd_accept = (state == S_IDLE) && i_cmd_stb;
        beat_acc   = o_wb_stb && !i_wb_stall;
        ack_v      = o_wb_cyc && i_wb_ack;
        err_v      = o_wb_cyc && i_wb_err;
        abort      = err_v || timeout_v;
        last_ack   = ack_v && !abort && ((acked + CNT_ONE) == n_beats);
        last_beat  = beat_acc && ((issued + CNT_ONE) == n_beats);
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [TOW-1:0] TO_ONE  = {{(TOW-1){1'b0}}, 1'b1};
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};

    logic [TOW-1:0] to_cnt;

    // Inactivity counter; any bus progress restarts the count
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            to_cnt <= '0;
        end else if (cmd_accept || beat_acc || ack_v) begin
            to_cnt <= '0;
        end else if (state == S_BUS) begin
            to_cnt <= to_cnt + TO_ONE;
        end
    end

    // Fire on the edge where the counter would reach its all-ones value
    assign timeout_v = (state == S_BUS) && !(beat_acc || ack_v) && (to_cnt == TO_LAST);
`else
    assign timeout_v = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (i_cmd_stb) begin
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (abort || last_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        busy_d    = (state_d == S_BUS);
        cyc_d     = (state_d == S_BUS);
        stb_d     = 1'b0;
        rsp_stb_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state)
            S_IDLE: begin
                stb_d = i_cmd_stb;
            end
            S_BUS: begin
                if (abort || last_ack || last_beat) begin
                    stb_d = 1'b0;
                end else begin
                    stb_d = o_wb_stb;
                end
                rsp_stb_d = ack_v && !abort && !o_wb_we;
                done_d    = abort || last_ack;
                err_d     = abort;
            end
            default: begin
                stb_d = 1'b0;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_busy    <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_rsp_stb <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_busy    <= busy_d;
            o_wb_cyc  <= cyc_d;
            o_wb_stb  <= stb_d;
            o_rsp_stb <= rsp_stb_d;
            o_done    <= done_d;
            o_err     <= err_d;
        end
    end

    // Command latch, beat counters, address stepping and read-data capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            n_beats    <= '0;
            issued     <= '0;
            acked      <= '0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
            o_rsp_data <= '0;
        end else begin
            if (cmd_accept) begin
                n_beats   <= {1'b0, i_cmd_len} + CNT_ONE;
                issued    <= '0;
                acked     <= '0;
                o_wb_we   <= i_cmd_we;
                o_wb_addr <= i_cmd_addr;
                o_wb_data <= i_cmd_data;
            end else if (state == S_BUS) begin
                if (beat_acc) begin
                    issued    <= issued + CNT_ONE;
                    o_wb_addr <= o_wb_addr + ADDR_ONE;
                end
                if (ack_v && !abort) begin
                    acked <= acked + CNT_ONE;
                end
            end
            if (rsp_stb_d) begin
                o_rsp_data <= i_wb_data;
            end
        end
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Pipelined Wishbone bus initiator (master) that turns a single command strobe into a burst of up to 2^LGLEN single-word bus requests. It drives the same stall/ack pipelined bus that our peripheral slaves (LED chaser and others) respond on. It sits between a command source (debug bridge, CPU-side sequencer) and the bus interconnect. Read data returns on a response strobe, and completion or error is reported on a done pulse.

## Interface
- AW, 30: Wishbone word-address width.
- DW, 32: data width.
- LGLEN, 4: burst-length field width; burst length = i_cmd_len+1, range 1..2^LGLEN.
- TOW, 10: timeout counter width (used only with the timeout feature).

- i_clk  in  1  single clock; all logic is rising-edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_stb  in  1  command request; accepted only when o_busy=0.
- i_cmd_we  in  1  1=write burst, 0=read burst.
- i_cmd_addr  in  AW  first word address.
- i_cmd_data  in  DW  write data; the same word is written on every beat (fill).
- i_cmd_len  in  LGLEN  beats minus one.
- o_busy  out  1  command in progress.
- o_rsp_stb  out  1  one-cycle pulse, read word valid.
- o_rsp_data  out  DW  read word.
- o_done  out  1  one-cycle pulse, burst finished or aborted.
- o_err  out  1  valid with o_done; 1=aborted.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus controls.
- o_wb_addr  out  AW;  o_wb_data  out  DW.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each.
- i_wb_data  in  DW.

## Operation
- States: IDLE, BUS, plus the timeout feature when compiled in.
- IDLE: o_busy=0, o_wb_cyc=o_wb_stb=0.
  - i_cmd_stb=1 latches we, addr, data and the beat count N=i_cmd_len+1.
  - Clears the issued and acked counters (LGLEN+1 bits each, so N=2^LGLEN does not wrap).
  - Moves to BUS.
- BUS, request side:
  - o_wb_stb=1 while issued<N.
  - A beat is accepted in a cycle with o_wb_stb && !i_wb_stall. On acceptance, issued increments and o_wb_addr increments by 1 (modulo 2^AW, wraps silently).
  - When issued reaches N, o_wb_stb drops at that edge.
  - o_wb_we, o_wb_data stay constant for the whole burst.
- BUS, response side:
  - Each i_wb_ack increments acked.
  - On a read, each ack also registers i_wb_data into o_rsp_data and pulses o_rsp_stb.
  - An ack and an accepted request in the same cycle are both counted.
- Normal completion: the ack that makes acked=N drops o_wb_cyc, returns to IDLE, and pulses o_done with o_err=0.
- Error abort: i_wb_err while cyc=1 drops o_wb_cyc and o_wb_stb, returns to IDLE, and pulses o_done with o_err=1.
  - An ack in the same cycle as err is ignored, so no o_rsp_stb is issued for it.
  - Remaining beats are not issued.
- i_wb_ack and i_wb_err are ignored while o_wb_cyc=0.
- i_cmd_stb is ignored while o_busy=1; commands are not queued.

## Timing
- Reset values: o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_rsp_stb, o_done, o_err = 0; o_wb_addr, o_wb_data, o_rsp_data = 0. State = IDLE.
- Reset mid-burst takes effect immediately (async); cyc drops with no done pulse.
- All outputs are registered.
- Command accepted at edge T: o_busy, o_wb_cyc, o_wb_stb high after T, i.e. first bus request visible in cycle T+1.
- With no stall, N beats occupy N consecutive stb cycles.
- Read data: o_rsp_stb is high the cycle after the ack, so latency is 1.
- Final ack at edge A:
  - o_wb_cyc=0 and o_busy=0 after A.
  - o_done=1 for the single cycle after A, coincident with the last o_rsp_stb on a read.
- Back-to-back: a new i_cmd_stb during the o_done cycle is accepted.
- Minimum idle gap on the bus is 1 cycle with cyc low.

## Configuration
- WB_INITIATOR_TIMEOUT_EN defined:
  - A TOW-bit counter clears on command accept, on any accepted beat, and on any ack.
  - It increments each BUS cycle otherwise.
  - When it reaches 2^TOW-1, the initiator aborts exactly as on i_wb_err (cyc/stb drop, o_done=1, o_err=1).
- Undefined:
  - No counter is built; a non-responding slave holds o_busy=1 until reset.
  - i_wb_err aborts remain active either way.

## Test plan
- Single write, addr=0x10, data=0xDEADBEEF, len=0, no stall, ack 1 cycle after stb:
  - exactly one stb with we=1, addr=0x10.
  - o_done=1, o_err=0 the cycle after the ack; cyc low the same cycle.
- Read burst len=3 from addr=0x3FFFFFFE, slave stalls the 2nd beat for 2 cycles, acks return data 1,2,3,4:
  - addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1.
  - o_rsp_stb ×4 with 1,2,3,4.
  - o_done coincides with the 4th rsp.
- Read burst len=2, i_wb_err on the 2nd ack slot:
  - one o_rsp_stb only; 3rd beat not issued after err.
  - o_done=1 with o_err=1.
- i_cmd_stb held high during a burst, then asserted in the o_done cycle:
  - the held-high requests are ignored.
  - the request in the o_done cycle starts a burst whose stb is visible the next cycle.
- With WB_INITIATOR_TIMEOUT_EN and TOW=4, slave never acks:
  - abort with o_done=1, o_err=1 fifteen cycles after the last accepted beat.
  - without the macro, o_busy stays 1.
- Async reset asserted mid-burst:
  - cyc, stb, busy go 0 immediately.
  - no o_done pulse.
  - the next command after release works normally.
